// File: rtl/sync_arbiter.sv
// -----------------------------------------------------------------------------
// sync_arbiter
//
// Round-robin arbiter and burst sequencer for the shared row-sync channel
// between per-bank cache controllers and backing storage. One requester is
// granted at a time. Its row addresses are latched at grant. The channel is
// then driven for an optional writeback burst followed by a fill burst, and
// the transfer ends with a one-cycle done pulse to the granted requester.
//
// Parameters
//   NREQ      number of requesters (2..16)
//   ADDRWIDTH backing-store row address width
//   CHWIDTH   cache row index width
//   BURSTLEN  beats per row transfer (power of two, >= 2)
//   TIMEOUT   stall-watchdog limit in cycles (watchdog build only)
//
// Optional feature
//   SYNC_ARB_WATCHDOG_EN  when defined, a transfer whose channel stalls for
//                         TIMEOUT consecutive cycles is aborted: done and err
//                         pulse together. When undefined, err is tied low and
//                         a stalled channel keeps the grant indefinitely.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   [NREQ]            level request, held until done
//   req_wb     in   [NREQ]            requester needs writeback before fill
//   req_row    in   [NREQ*ADDRWIDTH]  fill row address, slice i = requester i
//   req_wbrow  in   [NREQ*ADDRWIDTH]  evicted row address for writeback
//   req_crow   in   [NREQ*CHWIDTH]    cache row index
//   grant      out  [NREQ]            one-hot grant, zero when idle
//   done       out  [NREQ]            one-cycle completion pulse
//   err        out                    one-cycle watchdog abort pulse
//   ch_valid   out                    channel beat valid
//   ch_write   out                    1 = writeback beat, 0 = fill beat
//   ch_row     out  [ADDRWIDTH]       backing row address of current phase
//   ch_crow    out  [CHWIDTH]         cache row index
//   ch_beat    out  [log2(BURSTLEN)]  beat index within burst
//   ch_ready   in                     channel accepts current beat
// -----------------------------------------------------------------------------
module sync_arbiter #(
   parameter int NREQ      = 4,
   parameter int ADDRWIDTH = 17,
   parameter int CHWIDTH   = 6,
   parameter int BURSTLEN  = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ-1:0]               req_wb,
   input  logic [NREQ*ADDRWIDTH-1:0]     req_row,
   input  logic [NREQ*ADDRWIDTH-1:0]     req_wbrow,
   input  logic [NREQ*CHWIDTH-1:0]       req_crow,
   output logic [NREQ-1:0]               grant,
   output logic [NREQ-1:0]               done,
   output logic                          err,
   output logic                          ch_valid,
   output logic                          ch_write,
   output logic [ADDRWIDTH-1:0]          ch_row,
   output logic [CHWIDTH-1:0]            ch_crow,
   output logic [$clog2(BURSTLEN)-1:0]   ch_beat,
   input  logic                          ch_ready
);

   localparam int PW = $clog2(NREQ);
   localparam int BW = $clog2(BURSTLEN);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURSTLEN - 1);
   localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [NREQ-1:0]      grant_nxt;
   logic [NREQ-1:0]      done_nxt;
   logic                 err_nxt;
   logic                 ch_valid_nxt;
   logic                 ch_write_nxt;
   logic [ADDRWIDTH-1:0] ch_row_nxt;
   logic [CHWIDTH-1:0]   ch_crow_nxt;
   logic [BW-1:0]        ch_beat_nxt;
   logic [PW-1:0]        ptr, ptr_nxt;
   logic [PW-1:0]        gidx, gidx_nxt;       // index of the granted requester
   logic [ADDRWIDTH-1:0] fill_row, fill_row_nxt;  // fill row held during writeback
   logic [PW-1:0]        pick;
   logic                 accept;
   logic                 last_beat;
   logic                 wd_abort;

   // First requester at or after p, searching cyclically. Only called when
   // at least one request is set.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [PW-1:0]   p);
      logic [PW-1:0] sel;
      logic [PW:0]   sum;
      logic [PW-1:0] cand;
      logic          found;
      sel   = p;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         sum  = {1'b0, p} + (PW+1)'(k);
         cand = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
         if (!found && r[cand]) begin
            found = 1'b1;
            sel   = cand;
         end else begin
            sel   = sel;
         end
      end
      return sel;
   endfunction

   // Arbitration winner and beat handshake decode
   always_comb begin
      pick      = rr_pick(req, ptr);
      accept    = ch_valid && ch_ready;
      last_beat = accept && (ch_beat == LAST_BEAT);
   end

`ifdef SYNC_ARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wd_cnt, wd_cnt_nxt;
   logic          err_r;

   // Consecutive-stall counter; any accepted beat or leaving a burst clears it
   always_comb begin
      wd_cnt_nxt = '0;
      wd_abort   = 1'b0;
      if ((state == WB || state == FILL) && ch_valid && !ch_ready) begin
         if (wd_cnt == WW'(TIMEOUT - 1)) begin
            wd_abort   = 1'b1;
            wd_cnt_nxt = '0;
         end else begin
            wd_cnt_nxt = wd_cnt + WW'(1);
         end
      end else begin
         wd_cnt_nxt = '0;
      end
   end

   // Watchdog counter and error pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         err_r  <= 1'b0;
      end else begin
         wd_cnt <= wd_cnt_nxt;
         err_r  <= err_nxt;
      end
   end

   assign err = err_r;
`else
   // No watchdog: a stalled channel keeps the grant. TIMEOUT has no effect.
   assign wd_abort = 1'b0;
   assign err      = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      done_nxt     = '0;
      err_nxt      = 1'b0;
      ch_valid_nxt = ch_valid;
      ch_write_nxt = ch_write;
      ch_row_nxt   = ch_row;
      ch_crow_nxt  = ch_crow;
      ch_beat_nxt  = ch_beat;
      ptr_nxt      = ptr;
      gidx_nxt     = gidx;
      fill_row_nxt = fill_row;

      case (state)
         IDLE: begin
            if (|req) begin
               gidx_nxt     = pick;
               grant_nxt    = NREQ'(1) << pick;
               fill_row_nxt = req_row[int'(pick)*ADDRWIDTH +: ADDRWIDTH];
               ch_crow_nxt  = req_crow[int'(pick)*CHWIDTH +: CHWIDTH];
               ch_valid_nxt = 1'b1;
               ch_beat_nxt  = '0;
               if (req_wb[pick]) begin
                  state_nxt    = WB;
                  ch_write_nxt = 1'b1;
                  ch_row_nxt   = req_wbrow[int'(pick)*ADDRWIDTH +: ADDRWIDTH];
               end else begin
                  state_nxt    = FILL;
                  ch_write_nxt = 1'b0;
                  ch_row_nxt   = req_row[int'(pick)*ADDRWIDTH +: ADDRWIDTH];
               end
            end else begin
               state_nxt = IDLE;
            end
         end

         WB: begin
            if (wd_abort) begin
               state_nxt    = DONE;
               ch_valid_nxt = 1'b0;
               ch_beat_nxt  = '0;
               done_nxt     = grant;
               err_nxt      = 1'b1;
            end else if (last_beat) begin
               // Writeback finished: switch the channel to the latched fill row
               state_nxt    = FILL;
               ch_beat_nxt  = '0;
               ch_write_nxt = 1'b0;
               ch_row_nxt   = fill_row;
            end else if (accept) begin
               ch_beat_nxt = ch_beat + BW'(1);
            end else begin
               ch_beat_nxt = ch_beat;
            end
         end

         FILL: begin
            if (wd_abort) begin
               state_nxt    = DONE;
               ch_valid_nxt = 1'b0;
               ch_beat_nxt  = '0;
               done_nxt     = grant;
               err_nxt      = 1'b1;
            end else if (last_beat) begin
               state_nxt    = DONE;
               ch_valid_nxt = 1'b0;
               ch_beat_nxt  = '0;
               done_nxt     = grant;
            end else if (accept) begin
               ch_beat_nxt = ch_beat + BW'(1);
            end else begin
               ch_beat_nxt = ch_beat;
            end
         end

         DONE: begin
            // Grant stays up during the done pulse; search resumes after winner
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = (gidx == LAST_REQ) ? '0 : gidx + PW'(1);
         end

         default: begin
            state_nxt    = IDLE;
            grant_nxt    = '0;
            ch_valid_nxt = 1'b0;
            ch_beat_nxt  = '0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         done     <= '0;
         ch_valid <= 1'b0;
         ch_write <= 1'b0;
         ch_row   <= '0;
         ch_crow  <= '0;
         ch_beat  <= '0;
         ptr      <= '0;
         gidx     <= '0;
         fill_row <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         done     <= done_nxt;
         ch_valid <= ch_valid_nxt;
         ch_write <= ch_write_nxt;
         ch_row   <= ch_row_nxt;
         ch_crow  <= ch_crow_nxt;
         ch_beat  <= ch_beat_nxt;
         ptr      <= ptr_nxt;
         gidx     <= gidx_nxt;
         fill_row <= fill_row_nxt;
      end
   end

endmodule

// File: tb/tb_sync_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_arbiter: self-checking bench for sync_arbiter.
// Table-driven transactions, hand sequences for ready toggling, reset during
// writeback and stall behaviour, then random traffic against a beat-counting
// reference model.
// -----------------------------------------------------------------------------
module tb_sync_arbiter;
   localparam int NREQ = 4;
   localparam int AW   = 17;
   localparam int CW   = 6;
   localparam int BL   = 8;
   localparam int TO   = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req, req_wb;
   logic [NREQ*AW-1:0]   req_row, req_wbrow;
   logic [NREQ*CW-1:0]   req_crow;
   logic [NREQ-1:0]      grant, done;
   logic                 err, ch_valid, ch_write, ch_ready;
   logic [AW-1:0]        ch_row;
   logic [CW-1:0]        ch_crow;
   logic [2:0]           ch_beat;

   int total = 0;
   int bad   = 0;
   int m_ptr = 0;

   logic [AW-1:0] t_row   [NREQ] = '{17'h1A2B3, 17'h11111, 17'h0FFFF, 17'h1FFFF};
   logic [AW-1:0] t_wbrow [NREQ] = '{17'h0AAAA, 17'h15555, 17'h00010, 17'h00001};
   logic [CW-1:0] t_crow  [NREQ] = '{6'd5, 6'd17, 6'd42, 6'd63};
   logic [AW-1:0] m_row   [NREQ];
   logic [AW-1:0] m_wbrow [NREQ];
   logic [CW-1:0] m_crow  [NREQ];

   typedef struct {
      logic [NREQ-1:0] rq;
      logic [NREQ-1:0] wb;
      logic [NREQ-1:0] exp_grant;
      int              exp_done;
   } vec_t;

   always #5 clk = ~clk;

   sync_arbiter #(.NREQ(NREQ), .ADDRWIDTH(AW), .CHWIDTH(CW), .BURSTLEN(BL),
                  .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_wb(req_wb), .req_row(req_row),
      .req_wbrow(req_wbrow), .req_crow(req_crow), .grant(grant), .done(done),
      .err(err), .ch_valid(ch_valid), .ch_write(ch_write), .ch_row(ch_row),
      .ch_crow(ch_crow), .ch_beat(ch_beat), .ch_ready(ch_ready)
   );

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_data(input int i, input logic [AW-1:0] r, input logic [AW-1:0] w,
                           input logic [CW-1:0] c);
      req_row[i*AW +: AW]   = r;
      req_wbrow[i*AW +: AW] = w;
      req_crow[i*CW +: CW]  = c;
      m_row[i]   = r;
      m_wbrow[i] = w;
      m_crow[i]  = c;
   endtask

   task automatic load_table_data();
      for (int i = 0; i < NREQ; i++) set_data(i, t_row[i], t_wbrow[i], t_crow[i]);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
   task automatic run_vec(input vec_t v, input string tag);
      int gi;
      int len;
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (v.exp_grant[i]) gi = i;
      len      = v.exp_done - 1;
      req      = v.rq;
      req_wb   = v.wb;
      ch_ready = 1'b1;
      for (int c = 1; c <= len + 2; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check({tag, "_grant"}, 32'(grant), 32'(v.exp_grant));
            check({tag, "_crow"}, 32'(ch_crow), 32'(t_crow[gi]));
         end
         if (c <= len) begin
            check({tag, "_valid"}, 32'(ch_valid), 32'd1);
            check({tag, "_write"}, 32'(ch_write), 32'(v.wb[gi] && c <= BL));
            check({tag, "_beat"}, 32'(ch_beat), 32'((c - 1) % BL));
            check({tag, "_row"}, 32'(ch_row),
                  32'((v.wb[gi] && c <= BL) ? t_wbrow[gi] : t_row[gi]));
         end else if (c == len + 1) begin
            check({tag, "_done"}, 32'(done), 32'(v.exp_grant));
            check({tag, "_grant_at_done"}, 32'(grant), 32'(v.exp_grant));
            check({tag, "_valid_at_done"}, 32'(ch_valid), 32'd0);
            check({tag, "_err"}, 32'(err), 32'd0);
            req    = '0;
            req_wb = '0;
         end else begin
            check({tag, "_idle_grant"}, 32'(grant), 32'd0);
            check({tag, "_idle_done"}, 32'(done), 32'd0);
         end
      end
      m_ptr = (gi + 1) % NREQ;
   endtask

   initial begin
      vec_t          vt [7];
      logic [3:0]    pat;
      int            acc, p, w, len, last_w;
      bit            fin, e_wb, err_seen;
      logic [AW-1:0] e_row, e_wbrow;
      logic [CW-1:0] e_crow;

      // Reset values
      rst = 1'b1; req = '0; req_wb = '0; ch_ready = 1'b1;
      req_row = '0; req_wbrow = '0; req_crow = '0;
      load_table_data();
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_valid", 32'(ch_valid), 32'd0);
      check("rst_write", 32'(ch_write), 32'd0);
      check("rst_row", 32'(ch_row), 32'd0);
      check("rst_crow", 32'(ch_crow), 32'd0);
      check("rst_beat", 32'(ch_beat), 32'd0);
      rst = 1'b0;

      // Table: round-robin pointer walks 0 -> 1 -> 3 -> 1 -> 0 -> 2 -> 3 -> 1
      vt[0] = '{4'b0001, 4'b0000, 4'b0001, 1 + BL};
      vt[1] = '{4'b0100, 4'b0100, 4'b0100, 1 + 2*BL};
      vt[2] = '{4'b0011, 4'b0000, 4'b0001, 1 + BL};
      vt[3] = '{4'b1001, 4'b1000, 4'b1000, 1 + 2*BL};
      vt[4] = '{4'b0110, 4'b0000, 4'b0010, 1 + BL};
      vt[5] = '{4'b1111, 4'b0000, 4'b0100, 1 + BL};
      vt[6] = '{4'b0001, 4'b0001, 4'b0001, 1 + 2*BL};
      for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // ch_ready toggling 1,0,0,1 during a fill: beat advances only on ready
      pat = 4'b1001; acc = 0; p = 0; fin = 1'b0;
      req = 4'b0010; req_wb = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (acc == BL) begin
            check("tog_done", 32'(done), 32'b0010);
            check("tog_valid_end", 32'(ch_valid), 32'd0);
            req = '0; ch_ready = 1'b1; fin = 1'b1;
            break;
         end
         check("tog_grant", 32'(grant), 32'b0010);
         check("tog_valid", 32'(ch_valid), 32'd1);
         check("tog_beat", 32'(ch_beat), 32'(acc));
         check("tog_row", 32'(ch_row), 32'(t_row[1]));
         check("tog_write", 32'(ch_write), 32'd0);
         check("tog_no_early_done", 32'(done), 32'd0);
         ch_ready = pat[p];
         p = (p + 1) % 4;
         if (ch_ready) acc++;
      end
      check("tog_finished", 32'(fin), 32'd1);
      @(negedge clk);
      check("tog_idle_grant", 32'(grant), 32'd0);
      m_ptr = 2;

      // Random traffic against the reference model
      last_w = -1;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && i != last_w && $urandom_range(0, 1) == 1) begin
               req[i]    = 1'b1;
               req_wb[i] = 1'($urandom_range(0, 1));
               set_data(i, AW'($urandom), AW'($urandom), CW'($urandom));
            end
         end
         if (req == '0) begin
            req[(last_w + 1) % NREQ]    = 1'b1;
            req_wb[(last_w + 1) % NREQ] = 1'b0;
         end
         w = -1;
         for (int k = 0; k < NREQ; k++) if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         e_row = m_row[w]; e_wbrow = m_wbrow[w]; e_crow = m_crow[w]; e_wb = req_wb[w];
         len = e_wb ? 2 * BL : BL;
         acc = 0; fin = 1'b0;
         for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
               check("rnd_grant", 32'(grant), 32'(1 << w));
               check("rnd_crow", 32'(ch_crow), 32'(e_crow));
               // Inputs of the winner change after grant; latched values must rule
               req_wb[w] = ~req_wb[w];
               set_data(w, AW'($urandom), AW'($urandom), CW'($urandom));
            end
            if (acc == len) begin
               check("rnd_done", 32'(done), 32'(1 << w));
               check("rnd_grant_at_done", 32'(grant), 32'(1 << w));
               check("rnd_valid_at_done", 32'(ch_valid), 32'd0);
               check("rnd_err", 32'(err), 32'd0);
               req[w] = 1'b0; req_wb[w] = 1'b0; fin = 1'b1;
               break;
            end
            check("rnd_valid", 32'(ch_valid), 32'd1);
            check("rnd_write", 32'(ch_write), 32'(e_wb && acc < BL));
            check("rnd_beat", 32'(ch_beat), 32'(acc % BL));
            check("rnd_row", 32'(ch_row), 32'((e_wb && acc < BL) ? e_wbrow : e_row));
            check("rnd_no_early_done", 32'(done), 32'd0);
            ch_ready = ($urandom_range(0, 3) != 0);
            if (ch_ready) acc++;
         end
         check("rnd_finished", 32'(fin), 32'd1);
         ch_ready = 1'b1;
         @(negedge clk);
         check("rnd_idle_grant", 32'(grant), 32'd0);
         m_ptr  = (w + 1) % NREQ;
         last_w = w;
      end
      req = '0; req_wb = '0;
      @(negedge clk);

      // Reset on beat 3 of a writeback aborts without done
      load_table_data();
      req = 4'b0100; req_wb = 4'b0100;
      for (int c = 1; c <= 4; c++) @(negedge clk);
      check("rstwb_beat3", 32'(ch_beat), 32'd3);
      check("rstwb_write", 32'(ch_write), 32'd1);
      rst = 1'b1; req = '0; req_wb = '0;
      @(negedge clk);
      check("rstwb_grant", 32'(grant), 32'd0);
      check("rstwb_valid", 32'(ch_valid), 32'd0);
      check("rstwb_done", 32'(done), 32'd0);
      check("rstwb_beat", 32'(ch_beat), 32'd0);
      rst = 1'b0;
      // Pointer is back at 0: with everyone requesting, requester 0 wins
      vt[0] = '{4'b1111, 4'b0000, 4'b0001, 1 + BL};
      run_vec(vt[0], "post_rst");

      // Stalled channel
      req = 4'b0001; req_wb = '0; ch_ready = 1'b0;
`ifdef SYNC_ARB_WATCHDOG_EN
      for (int c = 1; c <= TO + 2; c++) begin
         @(negedge clk);
         if (c <= TO) begin
            check("wd_valid", 32'(ch_valid), 32'd1);
            check("wd_err_early", 32'(err), 32'd0);
         end else if (c == TO + 1) begin
            check("wd_err", 32'(err), 32'd1);
            check("wd_done", 32'(done), 32'b0001);
            req = '0;
         end else begin
            check("wd_grant_clear", 32'(grant), 32'd0);
            check("wd_err_clear", 32'(err), 32'd0);
         end
      end
`else
      err_seen = 1'b0;
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clk);
         if (err || done != '0) err_seen = 1'b1;
      end
      check("stall_grant", 32'(grant), 32'b0001);
      check("stall_valid", 32'(ch_valid), 32'd1);
      check("stall_beat", 32'(ch_beat), 32'd0);
      check("stall_no_err_done", 32'(err_seen), 32'd0);
      req = '0;
`endif
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sync_arbiter.md
# sync_arbiter

Round-robin arbiter and sequencer for the single shared row-sync channel between the emulated-memory cache controllers and backing storage. Each requester is a per-bank cache controller needing a cache row synchronised: an optional writeback of the evicted row, then a fill of the new row. The block grants one requester at a time and drives the channel for a fixed-length burst per phase. It signals completion with a one-cycle `done` pulse to the granted requester.

## Interface
- `NREQ`, 4: number of requesters (2..16).
- `ADDRWIDTH`, 17: backing-store row address width.
- `CHWIDTH`, 6: cache row index width.
- `BURSTLEN`, 8: beats per row transfer (power of two, ≥2).
- `TIMEOUT`, 255: stall-watchdog limit in cycles; used only with `SYNC_ARB_WATCHDOG_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester sync request; level, held until `done`.
- `req_wb`  in  NREQ  requester needs writeback before fill.
- `req_row`  in  NREQ*ADDRWIDTH  fill row address; slice i belongs to requester i.
- `req_wbrow`  in  NREQ*ADDRWIDTH  evicted row address for writeback.
- `req_crow`  in  NREQ*CHWIDTH  cache row index to sync.
- `grant`  out  NREQ  one-hot grant; all zero when idle.
- `done`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err`  out  1  one-cycle pulse on watchdog abort (tied 0 without macro).
- `ch_valid`  out  1  channel beat valid.
- `ch_write`  out  1  1 = writeback beat (cache→store), 0 = fill beat.
- `ch_row`  out  ADDRWIDTH  backing row address for current phase.
- `ch_crow`  out  CHWIDTH  cache row index.
- `ch_beat`  out  log2(BURSTLEN)  beat index within burst.
- `ch_ready`  in  1  channel accepts current beat.

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: if any `req` is high, pick the first set bit at or after `ptr` (cyclic), register `grant`, latch the winner's `req_row`/`req_wbrow`/`req_crow`/`req_wb`, and go to WB if `req_wb` else FILL. With no request, stay.
- WB: `ch_valid`=1, `ch_write`=1, `ch_row`=latched wbrow. Each cycle with `ch_valid && ch_ready` increments `ch_beat`. The beat at `BURSTLEN-1` accepted → `ch_beat`←0, go to FILL.
- FILL: same as WB with `ch_write`=0 and `ch_row`=latched fill row. The last beat accepted → DONE.
- DONE: `done[g]`=1 for one cycle, `grant` still asserted; `ptr`←g+1 mod NREQ; next state IDLE with `grant`←0.
- Latched addresses are used, so requester inputs may change after grant without effect.
- Requester contract: deassert `req` on the edge where `done` is sampled high. IDLE in the next cycle must not see it.
- `ch_valid`=0 in IDLE and DONE; `ch_row`/`ch_crow` hold their last value when `ch_valid`=0.

## Timing
- Reset values: state IDLE, `grant`=0, `done`=0, `err`=0, `ch_valid`=0, `ch_write`=0, `ch_row`=0, `ch_crow`=0, `ch_beat`=0, `ptr`=0.
- `rst` mid-transfer aborts immediately with no `done`. Requesters must reissue.
- Request at IDLE cycle 0 → `grant` and `ch_valid` high in cycle 1.
- With `ch_ready` constant 1: fill-only completes with `done` in cycle 1+BURSTLEN. Writeback+fill gives `done` in cycle 1+2·BURSTLEN.
- Back-to-back: the next grant appears at the earliest 2 cycles after `done` (DONE → IDLE → grant).
- Simultaneous requests: resolved by round-robin from `ptr`. The lowest index wins only when `ptr`=0.
- `ch_ready` low: beat, address and `ch_write` held stable, `ch_valid` stays high.

## Configuration
- `SYNC_ARB_WATCHDOG_EN` defined: a counter counts consecutive cycles of `ch_valid && !ch_ready` and clears on any accepted beat. On reaching `TIMEOUT`, go to DONE, pulse `err` together with `done[g]`, and update `ptr` as normal.
- Not defined: no counter; `err` tied 0; a stalled channel holds the grant indefinitely.

## Test plan
- Reset, then req=4'b0001, req_wb=0, row=0x1A2B3, crow=5, ch_ready=1 → grant=0001 at cycle 1, 8 fill beats with ch_beat 0..7 and ch_row=0x1A2B3, done[0] at cycle 9.
- req[2] with req_wb=1, wbrow=0x00010, row=0x0FFFF → 8 beats ch_write=1 row 0x00010, then 8 beats ch_write=0 row 0x0FFFF, done[2] at cycle 17.
- req=4'b1111 held, requesters re-raise after done → grant order 0,1,2,3,0. No requester is granted twice before all others are served.
- Toggle ch_ready 1,0,0,1,… during a fill → beat advances only on ready cycles, outputs stable while low, total beats exactly 8.
- Assert rst on beat 3 of a writeback → next cycle grant=0, ch_valid=0, no done. A following request starts at ch_beat 0.
- With SYNC_ARB_WATCHDOG_EN and TIMEOUT=16, hold ch_ready=0 → err and done[g] pulse together after 16 stalled cycles, grant clears next cycle. Without the macro, grant is still held after 1000 cycles.
